// File: rtl/rgb_hsv_pkg.sv
// Shared types and constants for the RGB to HSV pixel converter.
package rgb_hsv_pkg;

  typedef logic [7:0] rgb8_t;
  typedef logic [8:0] hue_t;

  typedef enum logic [1:0] {
    SEL_R = 2'd0,
    SEL_G = 2'd1,
    SEL_B = 2'd2
  } max_sel_t;

  localparam hue_t        HUE_SECTOR   = 9'd60;
  localparam hue_t        HUE_G_OFF    = 9'd120;
  localparam hue_t        HUE_B_OFF    = 9'd240;
  localparam hue_t        HUE_WRAP     = 9'd360;
  localparam int unsigned PIPE_LATENCY = 3;

endpackage

// File: rtl/rgb_2_hsv_if.sv
// Pixel bus for the converter: RGB in, HSV out, one pixel per clock.
interface rgb_2_hsv_if;
  import rgb_hsv_pkg::*;

  rgb8_t rgb_r;
  rgb8_t rgb_g;
  rgb8_t rgb_b;
  hue_t  hsv_h;
  rgb8_t hsv_s;
  rgb8_t hsv_v;

  // Pixel source side
  modport master (
    output rgb_r, rgb_g, rgb_b,
    input  hsv_h, hsv_s, hsv_v
  );

  // Converter side
  modport slave (
    input  rgb_r, rgb_g, rgb_b,
    output hsv_h, hsv_s, hsv_v
  );

endinterface

// File: rtl/rgb_2_hsv_udiv.sv
// Combinational unsigned divider, 16-bit dividend by 8-bit divisor.
// Divisor 0 yields quotient 0; quotients above 255 saturate (never reached by the converter).
module rgb_2_hsv_udiv (
  input  logic [15:0] dividend,
  input  logic [7:0]  divisor,
  output logic [7:0]  quotient
);

  logic [15:0] full;

  // Truncating divide with zero-divisor guard
  always_comb begin
    full = '0;
    if (divisor != 8'd0) begin
      full = dividend / {8'd0, divisor};
    end
    quotient = (full[15:8] != 8'd0) ? 8'hff : full[7:0];
  end

endmodule

// File: rtl/rgb_2_hsv.sv
// Three-stage pipelined RGB to HSV converter: extrema, divide, hue assemble.
module rgb_2_hsv
  import rgb_hsv_pkg::*;
(
  input logic        clk,
  input logic        rst,
  rgb_2_hsv_if.slave pix
);

  // Stage 1 combinational signals
  max_sel_t        c1_sel;
  rgb8_t           c1_max;
  rgb8_t           c1_min;
  logic signed [8:0] c1_diff;
  logic [8:0]      c1_abs;

  // Stage 1 registers
  max_sel_t s1_sel;
  rgb8_t    s1_max;
  rgb8_t    s1_delta;
  rgb8_t    s1_mag;
  logic     s1_neg;

  // Stage 2 signals and registers
  logic [15:0] hue_num;
  logic [15:0] sat_num;
  rgb8_t       c2_q;
  rgb8_t       c2_s;
  max_sel_t    s2_sel;
  rgb8_t       s2_q;
  rgb8_t       s2_s;
  rgb8_t       s2_max;
  logic        s2_neg;
  logic        s2_grey;

  // Stage 3 signals and output registers
  hue_t  c3_h;
  hue_t  out_h;
  rgb8_t out_s;
  rgb8_t out_v;

  // Max channel select (tie priority r > g > b), min, and signed hue difference
  always_comb begin
    if (pix.rgb_r >= pix.rgb_g && pix.rgb_r >= pix.rgb_b) begin
      c1_sel  = SEL_R;
      c1_max  = pix.rgb_r;
      c1_diff = $signed({1'b0, pix.rgb_g}) - $signed({1'b0, pix.rgb_b});
    end else if (pix.rgb_g >= pix.rgb_b) begin
      c1_sel  = SEL_G;
      c1_max  = pix.rgb_g;
      c1_diff = $signed({1'b0, pix.rgb_b}) - $signed({1'b0, pix.rgb_r});
    end else begin
      c1_sel  = SEL_B;
      c1_max  = pix.rgb_b;
      c1_diff = $signed({1'b0, pix.rgb_r}) - $signed({1'b0, pix.rgb_g});
    end
    if (pix.rgb_r <= pix.rgb_g) begin
      c1_min = (pix.rgb_r <= pix.rgb_b) ? pix.rgb_r : pix.rgb_b;
    end else begin
      c1_min = (pix.rgb_g <= pix.rgb_b) ? pix.rgb_g : pix.rgb_b;
    end
    c1_abs = c1_diff[8] ? 9'(-c1_diff) : 9'(c1_diff);
  end

  // Stage 1 register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_sel   <= SEL_R;
      s1_max   <= '0;
      s1_delta <= '0;
      s1_mag   <= '0;
      s1_neg   <= 1'b0;
    end else begin
      s1_sel   <= c1_sel;
      s1_max   <= c1_max;
      s1_delta <= c1_max - c1_min;
      s1_mag   <= c1_abs[7:0];
      s1_neg   <= c1_diff[8];
    end
  end

  // |diff| never exceeds delta, so 60*|diff|/delta stays within 0..60
  always_comb begin
    hue_num = 16'(s1_mag) * 16'(HUE_SECTOR);
    sat_num = 16'(s1_delta) * 16'd255;
  end

  rgb_2_hsv_udiv u_hue_div (
    .dividend (hue_num),
    .divisor  (s1_delta),
    .quotient (c2_q)
  );

  rgb_2_hsv_udiv u_sat_div (
    .dividend (sat_num),
    .divisor  (s1_max),
    .quotient (c2_s)
  );

  // Stage 2 register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_sel  <= SEL_R;
      s2_q    <= '0;
      s2_s    <= '0;
      s2_max  <= '0;
      s2_neg  <= 1'b0;
      s2_grey <= 1'b0;
    end else begin
      s2_sel  <= s1_sel;
      s2_q    <= c2_q;
      s2_s    <= c2_s;
      s2_max  <= s1_max;
      s2_neg  <= s1_neg;
      s2_grey <= (s1_delta == 8'd0);
    end
  end

  // Hue assembly; a tiny negative r-sector diff can floor q to 0, so 360 folds back to 0
  always_comb begin
    c3_h = '0;
    unique case (s2_sel)
      SEL_R:   c3_h = s2_neg ? HUE_WRAP - {1'b0, s2_q} : {1'b0, s2_q};
      SEL_G:   c3_h = s2_neg ? HUE_G_OFF - {1'b0, s2_q} : HUE_G_OFF + {1'b0, s2_q};
      SEL_B:   c3_h = s2_neg ? HUE_B_OFF - {1'b0, s2_q} : HUE_B_OFF + {1'b0, s2_q};
      default: c3_h = '0;
    endcase
    if (s2_grey || c3_h >= HUE_WRAP) begin
      c3_h = '0;
    end
  end

  // Output register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_h <= '0;
      out_s <= '0;
      out_v <= '0;
    end else begin
      out_h <= c3_h;
      out_s <= s2_s;
      out_v <= s2_max;
    end
  end

  assign pix.hsv_h = out_h;
  assign pix.hsv_s = out_s;
  assign pix.hsv_v = out_v;

endmodule

// File: tb/tb_rgb_2_hsv.sv
// Scoreboard bench for rgb_2_hsv: driver queues expected HSV, monitor checks on due cycle.
module tb_rgb_2_hsv;
  import rgb_hsv_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  rgb_2_hsv_if pix ();

  rgb_2_hsv dut (
    .clk (clk),
    .rst (rst),
    .pix (pix)
  );

  typedef struct {
    logic [8:0] h;
    logic [7:0] s;
    logic [7:0] v;
    int         due;
    int         tag;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   errs   = 0;
  int   checks = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Integer reference: textbook HSV with truncating divides, hue folded into 0..359
  function automatic logic [24:0] ref_hsv(input int r, input int g, input int b);
    int mx, mn, d, n, base, q, h, s;
    mx = (r >= g && r >= b) ? r : ((g >= b) ? g : b);
    mn = (r <= g && r <= b) ? r : ((g <= b) ? g : b);
    d  = mx - mn;
    h  = 0;
    if (d != 0) begin
      if (r == mx) begin
        n = g - b; base = 0;
      end else if (g == mx) begin
        n = b - r; base = 120;
      end else begin
        n = r - g; base = 240;
      end
      q = (60 * ((n < 0) ? -n : n)) / d;
      h = (n >= 0) ? base + q : base - q;
      if (h < 0) h = h + 360;
      if (h >= 360) h = h - 360;
    end
    s = (mx == 0) ? 0 : (255 * d) / mx;
    return {9'(h), 8'(s), 8'(mx)};
  endfunction

  task automatic send(input int r, input int g, input int b,
                      input int h, input int s, input int v, input int tag);
    exp_t e;
    @(negedge clk);
    pix.rgb_r = 8'(r);
    pix.rgb_g = 8'(g);
    pix.rgb_b = 8'(b);
    e.h   = 9'(h);
    e.s   = 8'(s);
    e.v   = 8'(v);
    e.due = cyc + 3;
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic check_zero(input int tag);
    checks++;
    if (pix.hsv_h != 9'd0 || pix.hsv_s != 8'd0 || pix.hsv_v != 8'd0) begin
      errs++;
      $display("FAIL zero tag=%0d got h=%0d s=%0d v=%0d want h=0 s=0 v=0",
               tag, pix.hsv_h, pix.hsv_s, pix.hsv_v);
    end
  endtask

  // Monitor: compare the head of the scoreboard on the cycle it is due
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      checks++;
      if (pix.hsv_h != e.h || pix.hsv_s != e.s || pix.hsv_v != e.v || pix.hsv_h > 9'd359) begin
        errs++;
        $display("FAIL pixel tag=%0d got h=%0d s=%0d v=%0d want h=%0d s=%0d v=%0d",
                 e.tag, pix.hsv_h, pix.hsv_s, pix.hsv_v, e.h, e.s, e.v);
      end
    end
  end

  initial begin
    logic [24:0] m;
    int          r, g, b, n;
    pix.rgb_r = 8'd0;
    pix.rgb_g = 8'd0;
    pix.rgb_b = 8'd0;
    #1 check_zero(0);
    repeat (3) @(negedge clk);
    check_zero(1);
    rst = 1'b1;

    // Primaries
    send(255, 0, 0,     0, 255, 255, 10);
    send(0, 255, 0,   120, 255, 255, 11);
    send(0, 0, 255,   240, 255, 255, 12);
    // Greys
    send(0, 0, 0,       0,   0,   0, 20);
    send(128, 128, 128, 0,   0, 128, 21);
    send(255, 255, 255, 0,   0, 255, 22);
    // Wrap and sign
    send(255, 0, 128, 330, 255, 255, 30);
    send(255, 128, 0,  30, 255, 255, 31);
    send(0, 128, 255, 210, 255, 255, 32);
    send(255, 0, 1,     0, 255, 255, 33);
    // Ties and small values
    send(255, 255, 0,  60, 255, 255, 40);
    send(100, 50, 50,   0, 127, 100, 41);
    send(50, 100, 100, 180, 127, 100, 42);
    send(1, 0, 0,       0, 255,   1, 43);
    send(0, 0, 1,     240, 255,   1, 44);
    send(10, 20, 30,  210, 170,  30, 45);
    send(30, 20, 10,   30, 170,  30, 46);

    // Mid-stream reset: in-flight pixels are discarded
    send(255, 0, 0,     0, 255, 255, 50);
    send(0, 255, 0,   120, 255, 255, 51);
    #2 rst = 1'b0;
    sb.delete();
    #1 check_zero(52);
    @(negedge clk);
    check_zero(53);
    @(negedge clk);
    check_zero(54);
    rst = 1'b1;
    pix.rgb_r = 8'd0;
    pix.rgb_g = 8'd255;
    pix.rgb_b = 8'd0;
    begin
      exp_t e;
      e.h = 9'd120; e.s = 8'd255; e.v = 8'd255; e.due = cyc + 3; e.tag = 55;
      sb.push_back(e);
    end
    @(negedge clk);
    check_zero(56);
    @(negedge clk);
    check_zero(57);

    // Random pixels against the reference model, back to back
    for (int i = 0; i < 2000; i++) begin
      r = int'($urandom_range(0, 255));
      g = int'($urandom_range(0, 255));
      b = int'($urandom_range(0, 255));
      m = ref_hsv(r, g, b);
      send(r, g, b, int'(m[24:16]), int'(m[15:8]), int'(m[7:0]), 1000 + i);
    end

    n = 0;
    while (sb.size() > 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    if (sb.size() > 0) begin
      checks++;
      errs++;
      $display("FAIL drain got %0d pending want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
